// File: rtl/regfile_pkg.sv
// Shared constants, state type and sweep-value helper for the regfile_mp register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned NUM_REGS_DEF = 8;
  localparam int unsigned SP_IDX_DEF   = 6;
  localparam logic [15:0] SP_RESET_DEF = 16'h0800;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } regfile_state_t;

  // Returned at the widest supported width; callers cast down to their DATA_W.
  function automatic logic [63:0] init_value(input int unsigned idx,
                                             input int unsigned sp_idx,
                                             input logic [63:0] sp_reset);
    return (idx == sp_idx) ? sp_reset : '0;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One asynchronous read port: address range check, zero-forcing while not ready,
// and optional same-cycle write forwarding (REGFILE_BYPASS_EN).
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic              active,
  input  logic [ADDR_W-1:0] addr,
`ifdef REGFILE_BYPASS_EN
  input  logic              wr_commit,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_byte,
`endif
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] raw;

  // Explicit match loop so addresses past NUM_REGS fall through to zero.
  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) raw = regs[i];
    end
  end

  always_comb begin
    data = '0;
    if (active) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_commit && (addr == wr_addr))
        data = wr_byte ? {raw[DATA_W-1:DATA_W/2], wr_data[DATA_W/2-1:0]} : wr_data;
      else
`endif
        data = raw;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with byte-lane writes and an init sweep after reset/clear.
// Optional macro REGFILE_BYPASS_EN enables write-to-read forwarding on both ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned       SP_IDX   = SP_IDX_DEF,
  parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_DEF,
  localparam int unsigned      ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_byte,
  input  logic              clr_req,
  output logic              ready
);

  regfile_state_t    state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic                       active;
  logic                       wr_commit;
  logic [DATA_W-DATA_W/2-1:0] wr_old_hi;
  logic [DATA_W-1:0]          wr_word;

  assign active    = (state == ST_READY);
  // A clear in the same cycle drops the write; out-of-range addresses never commit.
  assign wr_commit = active && wr_en && !clr_req && (32'(wr_addr) < NUM_REGS);

  always_comb begin
    wr_old_hi = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_addr == ADDR_W'(i)) wr_old_hi = regs[i][DATA_W-1:DATA_W/2];
    end
  end

  assign wr_word = wr_byte ? {wr_old_hi, wr_data[DATA_W/2-1:0]} : wr_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INIT;
      idx   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          regs[idx] <= DATA_W'(init_value(32'(idx), SP_IDX, 64'(SP_RESET)));
          if (idx == ADDR_W'(NUM_REGS - 1)) begin
            state <= ST_READY;
            ready <= 1'b1;
            idx   <= '0;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        ST_READY: begin
          if (clr_req) begin
            state <= ST_INIT;
            idx   <= '0;
            ready <= 1'b0;
          end else if (wr_commit) begin
            regs[wr_addr] <= wr_word;
          end
        end
      endcase
    end
  end

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rd_a (
    .regs      (regs),
    .active    (active),
    .addr      (ra_addr),
`ifdef REGFILE_BYPASS_EN
    .wr_commit (wr_commit),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_byte   (wr_byte),
`endif
    .data      (ra_data)
  );

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rd_b (
    .regs      (regs),
    .active    (active),
    .addr      (rb_addr),
`ifdef REGFILE_BYPASS_EN
    .wr_commit (wr_commit),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_byte   (wr_byte),
`endif
    .data      (rb_data)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: init sweep, writes, forwarding, clear, mid-sweep reset,
// and a NUM_REGS=6 instance for out-of-range addressing.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        rst_n, wr_en, wr_byte, clr_req, ready;
  logic [2:0]  ra_addr, rb_addr, wr_addr;
  logic [15:0] ra_data, rb_data, wr_data;

  logic        rst6, wr_en6, wr_byte6, clr_req6, ready6;
  logic [2:0]  ra_addr6, rb_addr6, wr_addr6;
  logic [15:0] ra_data6, rb_data6, wr_data6;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n),
    .ra_addr(ra_addr), .ra_data(ra_data), .rb_addr(rb_addr), .rb_data(rb_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte(wr_byte),
    .clr_req(clr_req), .ready(ready)
  );

  regfile_mp #(.DATA_W(16), .NUM_REGS(6), .SP_IDX(4), .SP_RESET(16'h0400)) dut6 (
    .clk(clk), .rst_n(rst6),
    .ra_addr(ra_addr6), .ra_data(ra_data6), .rb_addr(rb_addr6), .rb_data(rb_data6),
    .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6), .wr_byte(wr_byte6),
    .clr_req(clr_req6), .ready(ready6)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    bit          port_b;
    logic [15:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [2:0]  a;
    logic [2:0]  b;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;
  vec_t init_tbl[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic chk_ready(input string name, input logic act, input logic exp);
    chk(name, {15'b0, act}, {15'b0, exp});
  endtask

  task automatic push(input string name, input bit port_b, input logic [15:0] exp);
    sbq.push_back('{name, port_b, exp});
  endtask

  task automatic drain();
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.name, e.port_b ? rb_data : ra_data, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input bit byt);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_byte = byt;
    tick();
    wr_en = 1'b0; wr_byte = 1'b0;
  endtask

  task automatic run_init_tbl(input string tag);
    for (int unsigned i = 0; i < 8; i++) begin
      ra_addr = init_tbl[i].a;
      rb_addr = init_tbl[i].b;
      push($sformatf("%s_ra_r%0d", tag, init_tbl[i].a), 1'b0, init_tbl[i].ea);
      push($sformatf("%s_rb_r%0d", tag, init_tbl[i].b), 1'b1, init_tbl[i].eb);
      @(negedge clk);
      drain();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    init_tbl[0] = '{3'd0, 3'd7, 16'h0000, 16'h0000};
    init_tbl[1] = '{3'd1, 3'd6, 16'h0000, 16'h0800};
    init_tbl[2] = '{3'd2, 3'd5, 16'h0000, 16'h0000};
    init_tbl[3] = '{3'd3, 3'd4, 16'h0000, 16'h0000};
    init_tbl[4] = '{3'd4, 3'd3, 16'h0000, 16'h0000};
    init_tbl[5] = '{3'd5, 3'd2, 16'h0000, 16'h0000};
    init_tbl[6] = '{3'd6, 3'd1, 16'h0800, 16'h0000};
    init_tbl[7] = '{3'd7, 3'd0, 16'h0000, 16'h0000};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_byte = 1'b0; clr_req = 1'b0;
    ra_addr = 3'd6; rb_addr = 3'd0;
    rst6 = 1'b0; wr_en6 = 1'b0; wr_addr6 = '0; wr_data6 = '0; wr_byte6 = 1'b0; clr_req6 = 1'b0;
    ra_addr6 = '0; rb_addr6 = '0;

    // Reset, then the initial sweep.
    tick(); tick();
    chk_ready("reset_ready", ready, 1'b0);
    chk("reset_ra_zero", ra_data, 16'h0000);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_ready($sformatf("init_ready_e%0d", k), ready, k == 8);
      if (k == 7) chk("init_force_zero_r6", ra_data, 16'h0000);
    end
    run_init_tbl("init");

    // Full and byte-lane writes.
    ra_addr = 3'd3; rb_addr = 3'd3;
    wr(3'd3, 16'hBEEF, 1'b0);
    push("wr_full_ra", 1'b0, 16'hBEEF); push("wr_full_rb", 1'b1, 16'hBEEF);
    @(negedge clk); drain();
    wr(3'd3, 16'h0012, 1'b1);
    push("wr_byte_ra", 1'b0, 16'hBE12);
    @(negedge clk); drain();
    wr(3'd3, 16'hFF34, 1'b1);
    push("wr_byte_hi_ignored", 1'b0, 16'hBE34);
    @(negedge clk); drain();
    wr(3'd7, 16'hC3C3, 1'b0);
    ra_addr = 3'd7;
    push("wr_r7_ra", 1'b0, 16'hC3C3); push("wr_r7_keeps_r3", 1'b1, 16'hBE34);
    @(negedge clk); drain();

    // Same-cycle read of the register being written.
    ra_addr = 3'd2; rb_addr = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234; wr_byte = 1'b0;
    #1;
    push("byp_full_ra", 1'b0, BYP ? 16'h1234 : 16'h0000);
    push("byp_full_rb", 1'b1, BYP ? 16'h1234 : 16'h0000);
    drain();
    tick(); wr_en = 1'b0;
    push("post_full_ra", 1'b0, 16'h1234); push("post_full_rb", 1'b1, 16'h1234);
    drain();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0056; wr_byte = 1'b1;
    #1;
    push("byp_byte_ra", 1'b0, BYP ? 16'h1256 : 16'h1234);
    drain();
    tick(); wr_en = 1'b0; wr_byte = 1'b0;
    push("post_byte_ra", 1'b0, 16'h1256);
    drain();
    rb_addr = 3'd5;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5A5A;
    #1;
    push("byp_b_only_ra", 1'b0, 16'h1256);
    push("byp_b_only_rb", 1'b1, BYP ? 16'h5A5A : 16'h0000);
    drain();
    tick(); wr_en = 1'b0;
    push("post_b_rb", 1'b1, 16'h5A5A);
    drain();

    // Clear together with a write: write dropped, full resweep.
    wr(3'd6, 16'hFFFF, 1'b0);
    ra_addr = 3'd1; rb_addr = 3'd6;
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hAAAA;
    #1;
    chk("clr_drop_no_forward", ra_data, 16'h0000);
    chk("clr_pre_edge_r6", rb_data, 16'hFFFF);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) begin clr_req = 1'b0; wr_en = 1'b0; end
      chk_ready($sformatf("clr_ready_e%0d", k), ready, k == 9);
      if (k == 2) chk("clr_force_zero_rb", rb_data, 16'h0000);
      if (k == 4) clr_req = 1'b1;
      if (k == 5) clr_req = 1'b0;
      if (k == 8) begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h5555; end
      if (k == 9) wr_en = 1'b0;
    end
    run_init_tbl("clr");

    // Reset in the middle of a sweep restarts it.
    wr(3'd7, 16'h7777, 1'b0);
    wr(3'd3, 16'h3333, 1'b0);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk_ready("midsweep_ready", ready, 1'b0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_ready($sformatf("rst_ready_e%0d", k), ready, k == 8);
    end
    run_init_tbl("rst");

    // NUM_REGS=6 instance: address 7 is out of range.
    rst6 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_ready($sformatf("n6_ready_e%0d", k), ready6, k == 6);
    end
    ra_addr6 = 3'd7; rb_addr6 = 3'd4;
    wr_en6 = 1'b1; wr_addr6 = 3'd7; wr_data6 = 16'h9999;
    #1;
    chk("n6_oor_pre_edge", ra_data6, 16'h0000);
    chk("n6_sp_pre_edge", rb_data6, 16'h0400);
    tick(); wr_en6 = 1'b0;
    chk("n6_oor_post_edge", ra_data6, 16'h0000);
    rb_addr6 = 3'd6;
    #1;
    chk("n6_oor_rb6", rb_data6, 16'h0000);
    for (int unsigned i = 0; i < 6; i++) begin
      ra_addr6 = 3'(i);
      #2;
      chk($sformatf("n6_r%0d", i), ra_data6, (i == 4) ? 16'h0400 : 16'h0000);
    end

    chk("sb_empty", 16'(sbq.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
